// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// Holds the FSM state encoding and the datapath slice width.
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/four_bit_full_adder.sv
// Four-bit ripple adder slice: {C_o,S_o} = A_i + B_i + C_i.
module four_bit_full_adder (
    input  logic [3:0] A_i,
    input  logic [3:0] B_i,
    input  logic       C_i,
    output logic [3:0] S_o,
    output logic       C_o
);

    assign {C_o, S_o} = {1'b0, A_i} + {1'b0, B_i} + {4'b0000, C_i};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder on one shared four_bit_full_adder, LSB first.
// Optional subtract mode via `NSA_SUB_EN (adds the sub_i port).
module nibble_serial_adder_ctrl
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             C_i,
`ifdef NSA_SUB_EN
    input  logic             sub_i,
`endif
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] S_o,
    output logic             C_o
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    nsa_state_t          state;
    logic [IDX_W-1:0]    idx;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [WIDTH-1:0]    work;
    logic [WIDTH-1:0]    work_nxt;
    logic                carry_reg;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] sum;
    logic                cout;

    // Operands shift right each RUN edge so the active nibble is always at [3:0].
`ifdef NSA_SUB_EN
    logic sub_reg;
    assign b_nib = b_reg[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_reg}};
`else
    assign b_nib = b_reg[NIBBLE_W-1:0];
`endif

    // Result nibbles enter at the top and settle into place after NIBBLES edges.
    assign work_nxt = (work >> NIBBLE_W)
                    | (WIDTH'(sum) << (WIDTH - NIBBLE_W));

    four_bit_full_adder u_add (
        .A_i(a_reg[NIBBLE_W-1:0]),
        .B_i(b_nib),
        .C_i(carry_reg),
        .S_o(sum),
        .C_o(cout)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            work      <= '0;
            carry_reg <= 1'b0;
`ifdef NSA_SUB_EN
            sub_reg   <= 1'b0;
`endif
            S_o       <= '0;
            C_o       <= 1'b0;
            ready_o   <= 1'b1;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i && ready_o) begin
                        a_reg     <= A_i;
                        b_reg     <= B_i;
                        idx       <= '0;
`ifdef NSA_SUB_EN
                        sub_reg   <= sub_i;
                        carry_reg <= sub_i ? 1'b1 : C_i;
`else
                        carry_reg <= C_i;
`endif
                        state     <= RUN;
                        ready_o   <= 1'b0;
                        busy_o    <= 1'b1;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> NIBBLE_W;
                    b_reg     <= b_reg >> NIBBLE_W;
                    work      <= work_nxt;
                    carry_reg <= cout;
                    if (idx == LAST) begin
                        S_o    <= work_nxt;
                        C_o    <= cout;
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    ready_o <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
// Runs subtract vectors too when NSA_SUB_EN is defined.
module tb_nibble_serial_adder_ctrl;

    localparam int W  = 16;
    localparam int NB = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         ready, busy, done;
    logic [W-1:0] s;
    logic         cout;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start),
        .A_i    (a),
        .B_i    (b),
        .C_i    (cin),
`ifdef NSA_SUB_EN
        .sub_i  (sub),
`endif
        .ready_o(ready),
        .busy_o (busy),
        .done_o (done),
        .S_o    (s),
        .C_o    (cout)
    );

    always #5 clk = ~clk;

    // Transaction-level model: result is plain arithmetic, timing is a countdown.
    logic         m_ready = 1'b1, m_busy = 1'b0, m_done = 1'b0;
    logic [W-1:0] m_s = '0;
    logic         m_c = 1'b0;
    logic [W:0]   m_pend = '0;
    int           m_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready = 1'b1; m_busy = 1'b0; m_done = 1'b0;
            m_s = '0; m_c = 1'b0; m_cnt = 0;
        end else if (m_ready) begin
            if (start) begin
                if (sub)
                    m_pend = {1'b0, a} + {1'b0, ~b} + 17'd1;
                else
                    m_pend = {1'b0, a} + {1'b0, b} + {16'd0, cin};
                m_ready = 1'b0; m_busy = 1'b1; m_cnt = NB;
            end
        end else if (m_done) begin
            m_done = 1'b0; m_busy = 1'b0; m_ready = 1'b1;
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_done = 1'b1;
                {m_c, m_s} = m_pend;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model ready", 32'(ready), 32'(m_ready));
            check("model busy",  32'(busy),  32'(m_busy));
            check("model done",  32'(done),  32'(m_done));
            check("model S",     32'(s),     32'(m_s));
            check("model C",     32'(cout),  32'(m_c));
        end
    end

    task automatic run_op(input string name, input logic [W-1:0] ta,
                          input logic [W-1:0] tb, input logic tc,
                          input logic tsub, input bit inject,
                          input logic [W-1:0] prev_s,
                          input logic [W-1:0] exp_s, input logic exp_c);
        int n;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; cin = tc; sub = tsub;
        @(posedge clk);
        @(negedge clk);
        if (inject) begin
            start = 1'b1; a = 16'h0001; b = 16'h0000; cin = 1'b0;
        end else begin
            start = 1'b0;
        end
        check({name, " busy after accept"}, {30'd0, ready, busy}, 32'd1);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) break;
            check({name, " S held in RUN"}, 32'(s), 32'(prev_s));
        end
        start = 1'b0;
        check({name, " done latency"}, 32'(n), 32'(NB));
        check({name, " S"}, 32'(s), 32'(exp_s));
        check({name, " C"}, 32'(cout), 32'(exp_c));
        @(negedge clk);
        check({name, " done one cycle"}, {30'd0, done, ready}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset ready", 32'(ready), 32'd1);
        check("reset outs", {28'd0, busy, done, cout, |s}, 32'd0);
        chk_en = 1'b1;

        run_op("t1", 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0,
               16'h0000, 16'h2345, 1'b0);
        run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0,
               16'h2345, 16'h0000, 1'b1);
        run_op("t3", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0,
               16'h0000, 16'hFFFF, 1'b1);
        run_op("t4", 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1,
               16'hFFFF, 16'h2345, 1'b0);

        // Abort mid-RUN with an asynchronous reset.
        @(negedge clk);
        start = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5 S cleared", 32'(s), 32'd0);
        check("t5 flags", {29'd0, ready, busy, cout}, 32'd4);
        check("t5 done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5 no done", 32'(done), 32'd0);
        end
        run_op("t5b", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0,
               16'h0000, 16'h0100, 1'b0);

`ifdef NSA_SUB_EN
        run_op("t6a", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0,
               16'h0100, 16'hFFFE, 1'b0);
        run_op("t6b", 16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0,
               16'hFFFE, 16'h0002, 1'b1);
        run_op("t6c", 16'h0007, 16'h0005, 1'b1, 1'b0, 1'b0,
               16'h0002, 16'h000D, 1'b0);
`endif

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
